// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with input synchroniser, 3-sample majority voting,
// false-start rejection, break detection and a valid/accept output handshake.
// Ports:
//   clk50m, rst_n          system clock (rising edge), async active-low reset
//   rx                     asynchronous serial line, idle high
//   rx_data/rx_valid       received word, held until rx_valid & rx_accept
//   rx_accept              consumer takes the presented word
//   rx_parity_err          parity mismatch of presented word
//   rx_frame_err           a stop bit of presented word sampled low
//   rx_break               presented word is a break (all-zero frame)
//   rx_overrun             sticky: a frame was dropped since the last accept
//   rx_idle                receiver idle and synchronised line high
module uart_rx_cfg #(
   parameter int unsigned FCLK        = 50_000_000,
   parameter int unsigned BAUD        = 115_200,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk50m,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_accept,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_break,
   output logic                 rx_overrun,
   output logic                 rx_idle
);

   localparam int unsigned BIT_CNT = FCLK / BAUD;
   localparam int unsigned HALF    = BIT_CNT / 2;
   localparam int unsigned CNT_W   = $clog2(BIT_CNT);
   localparam int unsigned IDX_W   = 4;

   // Elaboration-time parameter legality
   if (BIT_CNT < 16) begin : g_bad_bitcnt
      $error("uart_rx_cfg: FCLK/BAUD must be >= 16");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY > 2) begin : g_bad_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx_cfg: SYNC_STAGES must be >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [1:0]             samp_q;
   logic [IDX_W-1:0]       idx_q;
   logic [DATA_BITS-1:0]   shreg_q;
   logic                   par_acc_q;
   logic                   par_err_q;
   logic                   ferr_q;
   logic                   zero_q;
   logic                   stop_idx_q;

   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q, perr_q, frerr_q, brk_q, ovr_q, idle_q;

   logic rxs_c, tick_c, maj_c, done_c, frame_ferr_c, frame_zero_c;

   assign rxs_c = sync_q[SYNC_STAGES-1];

   // Bit decision happens in the cycle of the third (HALF-1) sample
   assign tick_c = (cnt_q == CNT_W'(HALF - 1)) &&
                   (state_q != S_IDLE) && (state_q != S_BRK_WAIT);
   assign maj_c  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_c) | (samp_q[1] & rxs_c);

   assign done_c       = tick_c && (state_q == S_STOP) && (stop_idx_q == 1'(STOP_BITS - 1));
   assign frame_ferr_c = ferr_q | ~maj_c;
   assign frame_zero_c = zero_q & ~maj_c;

   // Input synchroniser, idles high
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   // Receive FSM with bit timing and frame accumulation
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         samp_q     <= '1;
         idx_q      <= '0;
         shreg_q    <= '0;
         par_acc_q  <= 1'b0;
         par_err_q  <= 1'b0;
         ferr_q     <= 1'b0;
         zero_q     <= 1'b0;
         stop_idx_q <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         idle_q <= (state_q == S_IDLE) && rxs_c;
         if (state_q != S_IDLE)
            cnt_q <= (cnt_q == '0) ? CNT_W'(BIT_CNT - 1) : cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(HALF + 1)) samp_q[0] <= rxs_c;
         if (cnt_q == CNT_W'(HALF))     samp_q[1] <= rxs_c;

         case (state_q)
            S_IDLE: begin
               if (!rxs_c) begin
                  cnt_q   <= CNT_W'(BIT_CNT - 1);
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (tick_c) begin
                  if (maj_c) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q    <= S_DATA;
                     idx_q      <= '0;
                     par_acc_q  <= 1'b0;
                     par_err_q  <= 1'b0;
                     ferr_q     <= 1'b0;
                     zero_q     <= 1'b1;
                     stop_idx_q <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               if (tick_c) begin
                  for (int unsigned i = 0; i < DATA_BITS; i++)
                     if (idx_q == IDX_W'(i)) shreg_q[i] <= maj_c;
                  par_acc_q <= par_acc_q ^ maj_c;
                  if (maj_c) zero_q <= 1'b0;
                  if (idx_q == IDX_W'(DATA_BITS - 1))
                     state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                  else
                     idx_q <= idx_q + IDX_W'(1);
               end
            end
            S_PARITY: begin
               if (tick_c) begin
                  // Odd mode: data ones plus parity bit must be odd
                  par_err_q <= (PARITY == 1) ? ~(par_acc_q ^ maj_c) : (par_acc_q ^ maj_c);
                  if (maj_c) zero_q <= 1'b0;
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (tick_c) begin
                  if (!maj_c) ferr_q <= 1'b1;
                  if (maj_c)  zero_q <= 1'b0;
                  if (done_c)
                     // Leave mid-bit so the next start edge is caught promptly
                     state_q <= frame_zero_c ? S_BRK_WAIT : S_IDLE;
                  else
                     stop_idx_q <= 1'b1;
               end
            end
            S_BRK_WAIT: begin
               if (rxs_c) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Output handshake and overrun tracking
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         frerr_q <= 1'b0;
         brk_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (done_c) begin
         if (!valid_q || rx_accept) begin
            data_q  <= shreg_q;
            valid_q <= 1'b1;
            perr_q  <= par_err_q;
            frerr_q <= frame_ferr_c;
            brk_q   <= frame_zero_c;
            ovr_q   <= 1'b0;
         end else begin
            ovr_q <= 1'b1;
         end
      end else if (valid_q && rx_accept) begin
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         frerr_q <= 1'b0;
         brk_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign rx_parity_err = perr_q;
   assign rx_frame_err  = frerr_q;
   assign rx_break      = brk_q;
   assign rx_overrun    = ovr_q;
   assign rx_idle       = idle_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances at 16 clk/bit
// (u0 8N1, u1 8E1, u2 7O2) driven by hand-built frames.
module tb_uart_rx_cfg;

   localparam int unsigned FCLK = 1_600_000;
   localparam int unsigned BAUD = 100_000;
   localparam int unsigned BITC = 16;

   logic clk50m = 1'b0;
   logic rst_n;
   logic rxl [3];
   logic accl [3];

   logic [7:0] d0_data, d1_data;
   logic [6:0] d2_data;
   logic d0_valid, d0_perr, d0_ferr, d0_brk, d0_ovr, d0_idle;
   logic d1_valid, d1_perr, d1_ferr, d1_brk, d1_ovr, d1_idle;
   logic d2_valid, d2_perr, d2_ferr, d2_brk, d2_ovr, d2_idle;

   int checks = 0;
   int errors = 0;

   always #5 clk50m = ~clk50m;

   uart_rx_cfg #(.FCLK(FCLK), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .SYNC_STAGES(2)) u0 (
      .clk50m(clk50m), .rst_n(rst_n), .rx(rxl[0]), .rx_data(d0_data),
      .rx_valid(d0_valid), .rx_accept(accl[0]), .rx_parity_err(d0_perr),
      .rx_frame_err(d0_ferr), .rx_break(d0_brk), .rx_overrun(d0_ovr),
      .rx_idle(d0_idle));

   uart_rx_cfg #(.FCLK(FCLK), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .SYNC_STAGES(2)) u1 (
      .clk50m(clk50m), .rst_n(rst_n), .rx(rxl[1]), .rx_data(d1_data),
      .rx_valid(d1_valid), .rx_accept(accl[1]), .rx_parity_err(d1_perr),
      .rx_frame_err(d1_ferr), .rx_break(d1_brk), .rx_overrun(d1_ovr),
      .rx_idle(d1_idle));

   uart_rx_cfg #(.FCLK(FCLK), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .SYNC_STAGES(2)) u2 (
      .clk50m(clk50m), .rst_n(rst_n), .rx(rxl[2]), .rx_data(d2_data),
      .rx_valid(d2_valid), .rx_accept(accl[2]), .rx_parity_err(d2_perr),
      .rx_frame_err(d2_ferr), .rx_break(d2_brk), .rx_overrun(d2_ovr),
      .rx_idle(d2_idle));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bit time on line d
   task automatic bit_t(input int d, input logic v);
      rxl[d] = v;
      repeat (BITC) @(negedge clk50m);
   endtask

   task automatic send(input int d, input logic [8:0] data, input int nbits,
                       input int par, input logic pbit, input int nstop, input logic stop2);
      bit_t(d, 1'b0);
      for (int i = 0; i < nbits; i++) bit_t(d, data[i]);
      if (par != 0) bit_t(d, pbit);
      bit_t(d, 1'b1);
      if (nstop == 2) bit_t(d, stop2);
      rxl[d] = 1'b1;
   endtask

   function automatic logic vsel(input int d);
      case (d)
         0:       return d0_valid;
         1:       return d1_valid;
         default: return d2_valid;
      endcase
   endfunction

   // Bounded wait; a timeout shows up in the following valid check
   task automatic wait_valid(input int d);
      int n = 0;
      while (vsel(d) !== 1'b1 && n < 400) begin
         @(negedge clk50m);
         n++;
      end
   endtask

   task automatic accept(input int d);
      @(negedge clk50m) accl[d] = 1'b1;
      @(negedge clk50m) accl[d] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rxl[i]  = 1'b1;
         accl[i] = 1'b0;
      end
      repeat (4) @(negedge clk50m);
      chk("reset_valid", 32'(d0_valid), 32'h0);
      chk("reset_data",  32'(d0_data),  32'h0);
      chk("reset_idle",  32'(d0_idle),  32'h1);
      chk("reset_ovr",   32'(d0_ovr),   32'h0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk50m);

      // 8N1 basic frame
      send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
      wait_valid(0);
      chk("a5_valid", 32'(d0_valid), 32'h1);
      chk("a5_data",  32'(d0_data),  32'hA5);
      chk("a5_perr",  32'(d0_perr),  32'h0);
      chk("a5_ferr",  32'(d0_ferr),  32'h0);
      chk("a5_brk",   32'(d0_brk),   32'h0);
      chk("a5_ovr",   32'(d0_ovr),   32'h0);
      accept(0);
      chk("a5_valid_after_accept", 32'(d0_valid), 32'h0);

      // Short glitch rejected
      rxl[0] = 1'b0;
      repeat (4) @(negedge clk50m);
      rxl[0] = 1'b1;
      repeat (16) @(negedge clk50m);
      chk("glitch_valid", 32'(d0_valid), 32'h0);
      chk("glitch_idle",  32'(d0_idle),  32'h1);

      // Overrun: second frame dropped while first is pending
      send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
      send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
      chk("ovr_valid", 32'(d0_valid), 32'h1);
      chk("ovr_data",  32'(d0_data),  32'h11);
      chk("ovr_flag",  32'(d0_ovr),   32'h1);
      accept(0);
      chk("ovr_valid_after_accept", 32'(d0_valid), 32'h0);
      chk("ovr_flag_after_accept",  32'(d0_ovr),   32'h0);

      // Break: line low for three frame times
      rxl[0] = 1'b0;
      repeat (3 * 10 * BITC) @(negedge clk50m);
      chk("brk_valid", 32'(d0_valid), 32'h1);
      chk("brk_data",  32'(d0_data),  32'h0);
      chk("brk_flag",  32'(d0_brk),   32'h1);
      chk("brk_ferr",  32'(d0_ferr),  32'h1);
      accept(0);
      repeat (2 * BITC) @(negedge clk50m);
      chk("brk_no_more_words", 32'(d0_valid), 32'h0);
      rxl[0] = 1'b1;
      repeat (2 * BITC) @(negedge clk50m);
      send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1);
      wait_valid(0);
      chk("post_brk_valid", 32'(d0_valid), 32'h1);
      chk("post_brk_data",  32'(d0_data),  32'h5A);
      chk("post_brk_brk",   32'(d0_brk),   32'h0);
      chk("post_brk_ferr",  32'(d0_ferr),  32'h0);

      // Reset mid-data while a word is pending
      bit_t(0, 1'b0);
      bit_t(0, 1'b1);
      bit_t(0, 1'b1);
      bit_t(0, 1'b1);
      rst_n  = 1'b0;
      rxl[0] = 1'b1;
      repeat (2) @(negedge clk50m);
      chk("rst_mid_valid", 32'(d0_valid), 32'h0);
      chk("rst_mid_data",  32'(d0_data),  32'h0);
      chk("rst_mid_idle",  32'(d0_idle),  32'h1);
      chk("rst_mid_brk",   32'(d0_brk),   32'h0);
      rst_n = 1'b1;
      repeat (2 * BITC) @(negedge clk50m);
      send(0, 9'h0C3, 8, 0, 1'b0, 1, 1'b1);
      wait_valid(0);
      chk("post_rst_valid", 32'(d0_valid), 32'h1);
      chk("post_rst_data",  32'(d0_data),  32'hC3);
      chk("post_rst_perr",  32'(d0_perr),  32'h0);
      accept(0);
      chk("post_rst_accept", 32'(d0_valid), 32'h0);

      // 8E1: 0x03 has two ones, so even parity bit is 0
      send(1, 9'h003, 8, 1, 1'b1, 1, 1'b1);
      wait_valid(1);
      chk("e1_bad_valid", 32'(d1_valid), 32'h1);
      chk("e1_bad_data",  32'(d1_data),  32'h03);
      chk("e1_bad_perr",  32'(d1_perr),  32'h1);
      chk("e1_bad_ferr",  32'(d1_ferr),  32'h0);
      accept(1);
      send(1, 9'h003, 8, 1, 1'b0, 1, 1'b1);
      wait_valid(1);
      chk("e1_good_data", 32'(d1_data), 32'h03);
      chk("e1_good_perr", 32'(d1_perr), 32'h0);
      chk("e1_good_brk",  32'(d1_brk),  32'h0);
      chk("e1_good_ovr",  32'(d1_ovr),  32'h0);
      accept(1);
      chk("e1_accept", 32'(d1_valid), 32'h0);

      // 7O2: 0x55 has four ones -> parity 1; 0x2A has three -> parity 0
      send(2, 9'h055, 7, 1, 1'b1, 2, 1'b1);
      wait_valid(2);
      chk("o2_good_data", 32'(d2_data), 32'h55);
      chk("o2_good_perr", 32'(d2_perr), 32'h0);
      chk("o2_good_ferr", 32'(d2_ferr), 32'h0);
      accept(2);
      send(2, 9'h02A, 7, 1, 1'b0, 2, 1'b0);
      wait_valid(2);
      chk("o2_stop2_valid", 32'(d2_valid), 32'h1);
      chk("o2_stop2_data",  32'(d2_data),  32'h2A);
      chk("o2_stop2_ferr",  32'(d2_ferr),  32'h1);
      chk("o2_stop2_brk",   32'(d2_brk),   32'h0);
      chk("o2_stop2_perr",  32'(d2_perr),  32'h0);
      accept(2);
      repeat (4 * BITC) @(negedge clk50m);
      chk("o2_no_spurious", 32'(d2_valid), 32'h0);
      chk("o2_ovr",         32'(d2_ovr),   32'h0);
      chk("idle_u0",        32'(d0_idle),  32'h1);
      chk("idle_u1",        32'(d1_idle),  32'h1);
      chk("idle_u2",        32'(d2_idle),  32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Configurable UART receiver that generalises the existing fixed 8N1 receiver.
- Frame format is set by parameters: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits.
- Adds an input synchroniser, 3-sample majority voting, false-start rejection and break detection.
- Delivers each frame through a valid/accept handshake with per-frame error flags and overrun detection.
- Sits between the board RX pin and byte-consuming logic (FIFO or command decoder) in the clk50m domain.

Parameters:
FCLK, 50_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bit/s; BIT_CNT = FCLK/BAUD must be >= 16 (elaboration assertion)
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
SYNC_STAGES, 2, synchroniser flops on rx, legal >= 2

Ports:
clk50m  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received word, stable while rx_valid = 1
rx_valid  out  1  word available; held until accepted
rx_accept  in  1  consumer takes word in any cycle where rx_valid & rx_accept
rx_parity_err  out  1  parity mismatch for presented word (0 when PARITY = 0)
rx_frame_err  out  1  a stop bit sampled low for presented word
rx_break  out  1  presented word is a break
rx_overrun  out  1  sticky: at least one frame dropped since last accept
rx_idle  out  1  FSM in IDLE and synchronised line high

Behaviour:
Reset and input synchroniser
- Reset values: rx_data = 0; rx_valid, all error flags, rx_overrun = 0; rx_idle = 1.
- Synchroniser flops reset to 1. All decisions use the synchronised signal rxs.

Sampling
- Bit-width counter reloads to BIT_CNT-1 at each bit start and counts down.
- Samples are taken at counter values HALF+1, HALF and HALF-1, where HALF = BIT_CNT/2.
- The bit value is the 2-of-3 majority, decided in the cycle of the HALF-1 sample.

States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: rxs == 0 -> load counter, go to START.
- START:
  - Majority 1 -> IDLE with no flags (glitch rejection).
  - Majority 0 -> DATA with bit index 0.
- DATA:
  - Each bit decision stores the bit at the current index.
  - After DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
- PARITY: decided bit is compared with the XOR of the data bits; odd mode requires a total of 1s that is odd.
- STOP:
  - Each stop bit is sampled; any low sample sets the frame-error candidate.
  - After the last stop decision, go to IDLE immediately (mid-bit) to allow resync on the next start edge.
- Break:
  - Condition: all data, parity and stop samples are 0.
  - The frame completes with rx_break = 1 and rx_frame_err = 1.
  - FSM enters BRK_WAIT, then goes to IDLE once rxs == 1.
- Completion timing: rx_valid rises on the clock edge after the final stop decision. Total pin-to-valid latency is SYNC_STAGES + 1 cycles after that mid-point.

Handshake
- On completion with rx_valid = 0: rx_data and the three per-frame flags load, rx_valid <= 1.
- rx_valid & rx_accept without a completion in the same cycle: rx_valid <= 0 and rx_overrun <= 0.
- Completion while rx_valid = 1 and no accept: new frame discarded, old word and flags unchanged, rx_overrun <= 1.
- Completion and accept in the same cycle: new word loads, rx_valid stays 1, rx_overrun <= 0.
- rx_accept while rx_valid = 0 is ignored.

Width and boundary rules
- DATA_BITS = 9 uses the full rx_data width.
- Error flags are meaningful only while rx_valid = 1; they are cleared together with rx_valid.
- A start edge arriving while rx_valid = 1 is still received.
- Asynchronous reset mid-frame: immediate return to reset values, FSM to IDLE, partial frame lost. After release the FSM waits for a fresh falling edge. A line that is already low counts as a start.

Test Plan:
1. FCLK=1_600_000, BAUD=100_000 (16 clk/bit), 8N1. Send 0xA5, accept 1 cycle after rx_valid -> rx_data=0xA5, all error flags 0, rx_valid low next cycle.
2. PARITY=2, 8E1. Send 0x03 with parity bit 1 -> rx_parity_err=1, rx_data=0x03. Same byte with parity 0 -> flag 0.
3. Low pulse of 4 clocks in IDLE -> no rx_valid, FSM back in IDLE, rx_idle=1 within 16 cycles.
4. Send 0x11 then 0x22 without accept, then accept -> rx_data=0x11, rx_overrun=1. After accept, rx_valid=0 and rx_overrun=0.
5. DATA_BITS=7, PARITY=1, STOP_BITS=2. Second stop bit driven low -> rx_frame_err=1, rx_break=0.
6. rx held low for 3 frame times -> one word 0x00 with rx_break=1 and rx_frame_err=1, no further words until rx high. A following 0x5A is received correctly. Separately, assert rst_n mid-data -> all outputs at reset values, and the next frame is received correctly.
